// File: rtl/gate_bist.sv
// Built-in stimulus/checker for a small combinational gate: sweeps every input
// vector, samples the gate output after a settle window and scores it against TRUTH.
module gate_bist #(
  parameter int                     N_IN   = 2,
  parameter logic [(1<<N_IN)-1:0]   TRUTH  = 4'b1000,
  parameter int                     SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            dut_y,
  output logic [N_IN-1:0] dut_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] fail_vec
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_CHECK  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [N_IN-1:0] VEC_ONE = N_IN'(1);
  localparam logic [N_IN:0]   ERR_ONE = (N_IN + 1)'(1);

  logic [1:0]      r_state;
  logic [N_IN-1:0] r_vec;
  logic [CW-1:0]   r_cnt;
  logic [N_IN:0]   r_err;
  logic [N_IN-1:0] r_fail_vec;
  logic            w_busy;
  logic            w_mismatch;

  // Case-inequality so an X/Z on the gate output is scored as a failure.
  assign w_mismatch = (dut_y !== TRUTH[r_vec]);
  assign w_busy     = (r_state == S_SETTLE) || (r_state == S_CHECK);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_vec      <= '0;
      r_cnt      <= '0;
      r_err      <= '0;
      r_fail_vec <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state    <= S_SETTLE;
            r_vec      <= '0;
            r_cnt      <= '0;
            r_err      <= '0;
            r_fail_vec <= '0;
          end
        end
        S_SETTLE: begin
          if (r_cnt == CNT_LAST) begin
            r_state <= S_CHECK;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_CHECK: begin
          if (w_mismatch) begin
            r_err <= r_err + ERR_ONE;
            if (r_err == '0) begin
              r_fail_vec <= r_vec;
            end
          end
          if (r_vec == '1) begin
            r_state <= S_DONE;
          end else begin
            r_vec   <= r_vec + VEC_ONE;
            r_cnt   <= '0;
            r_state <= S_SETTLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dut_in    = w_busy ? r_vec : '0;
  assign busy      = w_busy;
  assign done      = (r_state == S_DONE);
  assign pass      = (r_state == S_DONE) && (r_err == '0);
  assign err_count = r_err;
  assign fail_vec  = r_fail_vec;

endmodule

// File: tb/tb_gate_bist.sv
// Bench for gate_bist: two instances (default 2-input, and 3-input with SETTLE=1)
// driving a table-defined gate model, scored against an arithmetic reference.
module tb_gate_bist;

  logic       clk;
  logic       rst_n;
  logic       start0, start1;
  logic [3:0] dtt0;
  logic [7:0] dtt1;
  logic [1:0] din0;
  logic [2:0] din1;
  logic       busy0, busy1, done0, done1, pass0, pass1;
  logic [2:0] err0;
  logic [3:0] err1;
  logic [1:0] fv0;
  logic [2:0] fv1;
  logic       y0, y1;

  int n_checks;
  int n_errors;

  assign y0 = dtt0[din0];
  assign y1 = dtt1[din1];

  gate_bist u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .dut_y(y0), .dut_in(din0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_vec(fv0)
  );

  gate_bist #(.N_IN(3), .TRUTH(8'h80), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .dut_y(y1), .dut_in(din1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fv1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input int sel, input logic [31:0] e_in, input logic e_busy,
                            input logic e_done, input logic e_pass,
                            input logic [31:0] e_err, input logic [31:0] e_fv, input string ph);
    if (sel == 0) begin
      check({ph, "_in0"}, 32'(din0), e_in);
      check({ph, "_busy0"}, 32'(busy0), 32'(e_busy));
      check({ph, "_done0"}, 32'(done0), 32'(e_done));
      if (e_done) begin
        check({ph, "_pass0"}, 32'(pass0), 32'(e_pass));
        check({ph, "_err0"}, 32'(err0), e_err);
        check({ph, "_fv0"}, 32'(fv0), e_fv);
      end
    end else begin
      check({ph, "_in1"}, 32'(din1), e_in);
      check({ph, "_busy1"}, 32'(busy1), 32'(e_busy));
      check({ph, "_done1"}, 32'(done1), 32'(e_done));
      if (e_done) begin
        check({ph, "_pass1"}, 32'(pass1), 32'(e_pass));
        check({ph, "_err1"}, 32'(err1), e_err);
        check({ph, "_fv1"}, 32'(fv1), e_fv);
      end
    end
  endtask

  // One run: start pulse, then compare every cycle to the sweep schedule.
  // restart_at/abort_at are cycle offsets after the start edge (-1 = unused).
  task automatic run(input int sel, input logic [7:0] gate_tt,
                     input int restart_at, input int abort_at);
    int n_vec, settle, total, exp_err, exp_fv;
    logic [7:0] truth;
    if (sel == 0) begin
      n_vec = 4; settle = 2; truth = 8'h08; dtt0 = gate_tt[3:0];
    end else begin
      n_vec = 8; settle = 1; truth = 8'h80; dtt1 = gate_tt;
    end
    total   = n_vec * (settle + 1);
    exp_err = 0;
    exp_fv  = 0;
    for (int i = 0; i < n_vec; i++) begin
      if (gate_tt[i] != truth[i]) begin
        if (exp_err == 0) exp_fv = i;
        exp_err++;
      end
    end

    if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
    for (int k = 0; k <= total; k++) begin
      @(posedge clk);
      #1;
      start0 = 1'b0;
      start1 = 1'b0;
      if (k == 0) begin
        check("clear_err", (sel == 0) ? 32'(err0) : 32'(err1), 32'd0);
        check("clear_fv", (sel == 0) ? 32'(fv0) : 32'(fv1), 32'd0);
      end
      if (k < total)
        check_outs(sel, 32'(k / (settle + 1)), 1'b1, 1'b0, 1'b0, 0, 0, "run");
      else
        check_outs(sel, 32'd0, 1'b0, 1'b1, (exp_err == 0), 32'(exp_err), 32'(exp_fv), "end");
      if (k == restart_at) begin
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
      end
      if (k == abort_at) begin
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_outs(sel, 32'd0, 1'b0, 1'b0, 1'b0, 0, 0, "abort");
        check("abort_err", (sel == 0) ? 32'(err0) : 32'(err1), 32'd0);
        check("abort_fv", (sel == 0) ? 32'(fv0) : 32'(fv1), 32'd0);
        check("abort_pass", (sel == 0) ? 32'(pass0) : 32'(pass1), 32'd0);
        return;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    dtt0   = 4'b1000;
    dtt1   = 8'h80;
    repeat (2) @(posedge clk);
    #1;
    check_outs(0, 32'd0, 1'b0, 1'b0, 1'b0, 0, 0, "reset");
    check_outs(1, 32'd0, 1'b0, 1'b0, 1'b0, 0, 0, "reset");
    check("reset_err0", 32'(err0), 32'd0);
    check("reset_pass0", 32'(pass0), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run(0, 8'h08, -1, -1);   // AND gate
    run(0, 8'h0E, -1, -1);   // OR gate, restart from DONE
    run(0, 8'h00, -1, -1);   // stuck-at-0
    run(0, 8'h08, -1, 6);    // reset while vec=2 settles
    run(0, 8'h08, -1, -1);
    run(0, 8'h0E, 4, -1);    // start re-pulsed mid-run is ignored
    run(1, 8'h80, -1, -1);   // 3-input AND, SETTLE=1
    run(1, 8'hFE, -1, -1);
    for (int r = 0; r < 12; r++) begin
      run(r % 2, 8'($urandom), -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
